// File: rtl/inst_queue_mw.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_mw
// Purpose  : Multi-wide instruction fetch queue (IF -> ID) with squash and
//            post-redirect lane dropping.
// Revision : 1.0  initial release
// ============================================================================
module inst_queue_mw #(
  parameter int DEPTH     = 16,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int XLEN      = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [XLEN-1:0]                branch_target,
  input  logic [IN_WIDTH-1:0]            in_valid,
  input  logic [IN_WIDTH*32-1:0]         in_inst,
  input  logic [IN_WIDTH*XLEN-1:0]       in_pc,
  input  logic [IN_WIDTH*XLEN-1:0]       in_npc,
  output logic                           in_ready,
  output logic [OUT_WIDTH-1:0]           out_valid,
  output logic [OUT_WIDTH*32-1:0]        out_inst,
  output logic [OUT_WIDTH*XLEN-1:0]      out_pc,
  output logic [OUT_WIDTH*XLEN-1:0]      out_npc,
  input  logic [$clog2(OUT_WIDTH+1)-1:0] out_take,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int PW   = ADDR + 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int LW   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  logic [31:0]     r_inst [DEPTH];
  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [XLEN-1:0] r_npc  [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_drop_pending;
  logic [LW-1:0]   r_drop_lane;

  logic                w_ready;
  logic                w_push;
  logic [IN_WIDTH-1:0] w_acc;
  logic [CW-1:0]       w_off  [IN_WIDTH];
  logic [ADDR-1:0]     w_widx [IN_WIDTH];
  logic [CW-1:0]       w_npush;
  logic [CW-1:0]       w_push_n;
  logic [CW-1:0]       w_pop_n;
  logic [LW-1:0]       w_tgt_lane;

  generate
    if (IN_WIDTH > 1) begin : g_lane_multi
      assign w_tgt_lane = branch_target[2 +: LW];
    end else begin : g_lane_single
      assign w_tgt_lane = '0;
    end
  endgenerate

  logic w_unused_tgt;
  assign w_unused_tgt = ^branch_target;

  // Readiness deliberately ignores any same-cycle pop.
  assign w_ready  = (r_count <= CW'(DEPTH - IN_WIDTH));
  assign w_push   = w_ready && (|in_valid) && !squash;
  assign w_push_n = w_push ? w_npush : '0;
  assign w_pop_n  = squash ? '0 : CW'(out_take);
  assign in_ready = w_ready;
  assign count    = r_count;

  // Compaction: each surviving lane lands at tail + (survivors below it).
  always_comb begin
    w_npush = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_acc[i]  = in_valid[i] && !(r_drop_pending && (LW'(i) < r_drop_lane));
      w_off[i]  = w_npush;
      w_widx[i] = r_tail[ADDR-1:0] + w_off[i][ADDR-1:0];
      w_npush   = w_npush + CW'(w_acc[i]);
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_WIDTH; j++) begin
      logic [ADDR-1:0] w_ridx;
      w_ridx                 = r_head[ADDR-1:0] + ADDR'(j);
      out_valid[j]           = (CW'(j) < r_count);
      out_inst[32*j +: 32]   = out_valid[j] ? r_inst[w_ridx] : '0;
      out_pc[XLEN*j +: XLEN] = out_valid[j] ? r_pc[w_ridx]   : '0;
      out_npc[XLEN*j +: XLEN] = out_valid[j] ? r_npc[w_ridx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (w_acc[i]) begin
          r_inst[w_widx[i]] <= in_inst[32*i +: 32];
          r_pc[w_widx[i]]   <= in_pc[XLEN*i +: XLEN];
          r_npc[w_widx[i]]  <= in_npc[XLEN*i +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_drop_pending <= 1'b0;
      r_drop_lane    <= '0;
    end else if (squash) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_drop_pending <= 1'b1;
      r_drop_lane    <= w_tgt_lane;
    end else begin
      r_head  <= r_head + PW'(w_pop_n);
      r_tail  <= r_tail + PW'(w_push_n);
      r_count <= r_count + w_push_n - w_pop_n;
      if (w_push) begin
        r_drop_pending <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      assert (r_count <= CW'(DEPTH))
        else $error("inst_queue_mw: occupancy above capacity");
      if (!squash) begin
        assert ((CW'(out_take) <= r_count) && (32'(out_take) <= OUT_WIDTH))
          else $error("inst_queue_mw: out_take exceeds presented entries");
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_queue_mw.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue_mw
// Purpose  : Randomized scoreboard bench for inst_queue_mw with directed cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_queue_mw;

  localparam int DEPTH = 16;
  localparam int INW   = 2;
  localparam int OUTW  = 2;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          squash = 1'b0;
  logic [31:0]   branch_target = '0;
  logic [1:0]    in_valid = '0;
  logic [63:0]   in_inst = '0;
  logic [63:0]   in_pc = '0;
  logic [63:0]   in_npc = '0;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [63:0]   out_inst;
  logic [63:0]   out_pc;
  logic [63:0]   out_npc;
  logic [1:0]    out_take = '0;
  logic [4:0]    count;

  ent_t exp_q[$];
  bit   m_drop_pending = 0;
  int   m_drop_lane = 0;
  bit   mon_en = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  inst_queue_mw #(.DEPTH(DEPTH), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .squash(squash), .branch_target(branch_target),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_npc(in_npc),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_npc(out_npc), .out_take(out_take), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; the reference queue is updated as the group is issued.
  task automatic drive(input bit rst, input bit sq, input logic [31:0] tgt,
                       input logic [1:0] v, input logic [31:0] pc0, input int take);
    int   sz;
    int   tk;
    ent_t e [INW];
    @(negedge clock);
    #1;
    sz = exp_q.size();
    tk = (rst || sq) ? 0 : take;
    if (tk > sz) tk = sz;
    if (tk > OUTW) tk = OUTW;
    reset = rst;
    squash = sq;
    branch_target = tgt;
    in_valid = v;
    out_take = 2'(tk);
    for (int i = 0; i < INW; i++) begin
      e[i].inst = $urandom;
      e[i].pc   = pc0 + 32'(4 * i);
      e[i].npc  = pc0 + 32'(4 * i + 4);
      in_inst[32*i +: 32] = e[i].inst;
      in_pc[32*i +: 32]   = e[i].pc;
      in_npc[32*i +: 32]  = e[i].npc;
    end
    if (rst) begin
      exp_q.delete();
      m_drop_pending = 0;
    end else if (sq) begin
      exp_q.delete();
      m_drop_pending = 1;
      m_drop_lane = int'(tgt[2]);
    end else if ((DEPTH - sz) >= INW && v != 2'b00) begin
      for (int i = 0; i < INW; i++)
        if (v[i] && !(m_drop_pending && i < m_drop_lane)) exp_q.push_back(e[i]);
      m_drop_pending = 0;
    end
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 2'b00, 32'h0, 0);
  endtask

  // Monitor: compare presented head entries against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        check("count", 64'(count), 64'(exp_q.size()));
        check("in_ready", 64'(in_ready), 64'((DEPTH - exp_q.size()) >= INW));
        for (int j = 0; j < OUTW; j++) begin
          if (j < exp_q.size()) begin
            check("out_valid", 64'(out_valid[j]), 64'd1);
            check("out_pc", 64'(out_pc[32*j +: 32]), 64'(exp_q[j].pc));
            check("out_npc", 64'(out_npc[32*j +: 32]), 64'(exp_q[j].npc));
            check("out_inst", 64'(out_inst[32*j +: 32]), 64'(exp_q[j].inst));
          end else begin
            check("out_valid_empty", 64'(out_valid[j]), 64'd0);
            check("out_pc_empty", 64'(out_pc[32*j +: 32]), 64'd0);
          end
        end
      end
    end
  end

  // Consumed entries leave the scoreboard at the edge that takes them.
  initial begin
    forever begin
      @(posedge clock);
      for (int k = 0; k < int'(out_take); k++)
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] pc;
    drive(1, 0, 0, 2'b00, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0);
    mon_en = 1;
    idle();
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);

    drive(0, 0, 0, 2'b11, 32'h0, 0);
    idle();
    check("t1_out_valid", 64'(out_valid), 64'b11);
    check("t1_pc0", 64'(out_pc[31:0]), 64'h0);
    check("t1_pc1", 64'(out_pc[63:32]), 64'h4);
    check("t1_count", 64'(count), 64'd2);
    drive(0, 0, 0, 2'b00, 0, 2);

    drive(0, 0, 0, 2'b10, 32'h10, 0);
    idle();
    check("t2_out_valid", 64'(out_valid), 64'b01);
    check("t2_pc0", 64'(out_pc[31:0]), 64'h14);
    drive(0, 0, 0, 2'b00, 0, 1);

    pc = 32'h1000;
    for (int g = 0; g < 8; g++) begin
      drive(0, 0, 0, 2'b11, pc, 0);
      pc += 8;
    end
    idle();
    check("t3_full_count", 64'(count), 64'd16);
    check("t3_full_ready", 64'(in_ready), 64'd0);
    drive(0, 0, 0, 2'b11, pc, 0);
    idle();
    check("t3_ignored", 64'(count), 64'd16);
    drive(0, 0, 0, 2'b00, 0, 2);
    idle();
    check("t3_ready_again", 64'(in_ready), 64'd1);
    check("t3_count14", 64'(count), 64'd14);

    for (int g = 0; g < 3; g++) begin
      drive(0, 0, 0, 2'b11, pc, 2);
      pc += 8;
    end
    idle();
    check("t4_count", 64'(count), 64'd14);
    for (int g = 0; g < 7; g++) drive(0, 0, 0, 2'b00, 0, 2);

    drive(0, 1, 32'h104, 2'b00, 0, 0);
    idle();
    check("t5_sq_count", 64'(count), 64'd0);
    drive(0, 0, 0, 2'b11, 32'h100, 0);
    idle();
    check("t5_count", 64'(count), 64'd1);
    check("t5_pc", 64'(out_pc[31:0]), 64'h104);
    drive(0, 0, 0, 2'b00, 0, 1);

    drive(0, 1, 32'h0, 2'b11, 32'h200, 0);
    idle();
    check("t6_sq_push", 64'(count), 64'd0);
    drive(0, 0, 0, 2'b11, 32'h300, 0);
    drive(0, 0, 0, 2'b11, 32'h308, 1);
    drive(1, 0, 0, 2'b11, 32'h310, 0);
    idle();
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd1);

    pc = 32'h8000;
    for (int c = 0; c < 600; c++) begin
      bit          r;
      bit          s;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 19) == 0);
      t = $urandom;
      drive(r, s, t, 2'($urandom_range(0, 3)), pc, int'($urandom_range(0, 2)));
      pc += 8;
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
